// File: rtl/dp_issuer_if.sv
// dp_issuer_if: command, datapath and result signals of dp_issuer.
// The slave modport is the issuer's view. The master modport is the
// surrounding environment: the command source, the datapath and the result
// consumer.
interface dp_issuer_if #(
  parameter int N = 16
);
  logic         cmd_valid;
  logic         cmd_ready;
  logic [N-1:0] cmd_a;
  logic [N-1:0] cmd_b;
  logic [2:0]   cmd_op;
  logic [N-1:0] dp_a;
  logic [N-1:0] dp_b;
  logic [2:0]   dp_op;
  logic [N-1:0] dp_y;
  logic         dp_co;
  logic         res_valid;
  logic         res_ready;
  logic [N-1:0] res_y;
  logic         res_co;
  logic [2:0]   res_flags;
  logic         busy;

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, dp_y, dp_co, res_ready,
    output cmd_ready, dp_a, dp_b, dp_op, res_valid, res_y, res_co,
           res_flags, busy
  );

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op, dp_y, dp_co, res_ready,
    input  cmd_ready, dp_a, dp_b, dp_op, res_valid, res_y, res_co,
           res_flags, busy
  );
endinterface

// File: rtl/dp_issuer.sv
// dp_issuer: command front end for the arithmetic datapath.
// The issuer registers each command into the datapath. It tracks the
// in-flight operations through a LAT+1 stage valid pipe. It captures the
// datapath result on the return cycle into a result FIFO. Credits keep that
// FIFO from ever overflowing.
// Optional feature: define DP_ISSUER_FLAGS_EN to compute {ovf, neg, zero}.
// When it is undefined, res_flags is tied to 0.
module dp_issuer #(
  parameter int N     = 16,
  parameter int LAT   = 1,
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  dp_issuer_if.slave bus
);

  localparam int ST = LAT + 1;                  // valid pipe stages
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + ST + 1) + 1;
  localparam int FW = N + 4;                    // {y, co, flags}

  logic [N-1:0]  dp_a_q, dp_b_q;
  logic [2:0]    dp_op_q;
  logic [ST-1:0] vld_q;
  logic          out_of_rst_q;
  logic [AW:0]   wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d, fifo_count;
  logic [FW-1:0] mem_q [DEPTH];
  logic [FW-1:0] head_q, head_d, wdata;
  logic          res_valid_q;
  logic [CW-1:0] inflight, used;
  logic          accept, push, pop;
  logic [2:0]    wflags;

  assign accept     = bus.cmd_valid & bus.cmd_ready;
  assign push       = vld_q[ST-1];
  assign pop        = res_valid_q & bus.res_ready;
  assign fifo_count = wr_ptr_q - rd_ptr_q;

  // Count the operations still travelling through the datapath.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < ST; i++) begin
      inflight = inflight + {{(CW-1){1'b0}}, vld_q[i]};
    end
  end

  // Credits: stored plus in-flight results never exceed the FIFO depth.
  // cmd_ready stays low until the cycle after the releasing edge.
  assign used          = CW'(fifo_count) + inflight;
  assign bus.cmd_ready = rst_n & out_of_rst_q & (used < CW'(DEPTH));

  // Track the first edge with reset released.
  always_ff @(posedge clk) begin
    if (!rst_n) out_of_rst_q <= 1'b0;
    else        out_of_rst_q <= 1'b1;
  end

  // Load the datapath operand registers on accept. They hold while idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dp_a_q  <= '0;
      dp_b_q  <= '0;
      dp_op_q <= '0;
    end else if (accept) begin
      dp_a_q  <= bus.cmd_a;
      dp_b_q  <= bus.cmd_b;
      dp_op_q <= bus.cmd_op;
    end
  end

  // The valid pipe follows each issued operation to its return cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= '0;
    end else begin
      for (int i = ST - 1; i > 0; i--) vld_q[i] <= vld_q[i-1];
      vld_q[0] <= accept;
    end
  end

`ifdef DP_ISSUER_FLAGS_EN
  logic [ST-1:0] sa_q, sb_q;
  logic          eff_b_sign;

  // The sign of the effective B follows the opcode's zero and invert controls.
  assign eff_b_sign = bus.cmd_op[2] ? 1'b0 :
                      (bus.cmd_op[1] ? ~bus.cmd_b[N-1] : bus.cmd_b[N-1]);

  // Carry the operand signs alongside the valid bits for the overflow flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sa_q <= '0;
      sb_q <= '0;
    end else begin
      for (int i = ST - 1; i > 0; i--) begin
        sa_q[i] <= sa_q[i-1];
        sb_q[i] <= sb_q[i-1];
      end
      sa_q[0] <= bus.cmd_a[N-1];
      sb_q[0] <= eff_b_sign;
    end
  end

  // Build the flags from the returning result and the stored signs.
  always_comb begin
    wflags    = 3'b000;
    wflags[0] = (bus.dp_y == '0);
    wflags[1] = bus.dp_y[N-1];
    wflags[2] = (sa_q[ST-1] == sb_q[ST-1]) & (bus.dp_y[N-1] != sa_q[ST-1]);
  end
`else
  assign wflags = 3'b000;
`endif

  assign wdata    = {bus.dp_y, bus.dp_co, wflags};
  assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
  assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};

  // Write the result storage. It is never reset: only entries between the
  // pointers are meaningful.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

  // Pick the next head. An entry written this edge bypasses the storage when
  // it becomes the head. The old head is held when the FIFO drains.
  always_comb begin
    head_d = head_q;
    if (wr_ptr_d != rd_ptr_d) begin
      if (push && (rd_ptr_d == wr_ptr_q)) head_d = wdata;
      else                                head_d = mem_q[rd_ptr_d[AW-1:0]];
    end
  end

  // Update the FIFO pointers and the registered result head.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      head_q      <= '0;
      res_valid_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      head_q      <= head_d;
      res_valid_q <= (wr_ptr_d != rd_ptr_d);
    end
  end

  assign bus.dp_a      = dp_a_q;
  assign bus.dp_b      = dp_b_q;
  assign bus.dp_op     = dp_op_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_y     = head_q[FW-1:4];
  assign bus.res_co    = head_q[3];
  assign bus.res_flags = head_q[2:0];
  assign bus.busy      = (|vld_q) | (wr_ptr_q != rd_ptr_q);

endmodule

// File: tb/tb_dp_issuer.sv
// tb_dp_issuer: directed bench for dp_issuer with N=16, LAT=1, DEPTH=4.
// The bench contains a one-cycle adder model of the datapath.
module tb_dp_issuer;

`ifdef DP_ISSUER_FLAGS_EN
  localparam bit FLAGS_EN = 1'b1;
`else
  localparam bit FLAGS_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_bad;

  dp_issuer_if #(.N(16)) bus ();

  dp_issuer #(.N(16), .LAT(1), .DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The datapath model is an adder with a one-cycle latency.
  logic [15:0] m_effb;
  logic [16:0] m_sum;
  assign m_effb = bus.dp_op[2] ? 16'h0000 : (bus.dp_op[1] ? ~bus.dp_b : bus.dp_b);
  assign m_sum  = {1'b0, bus.dp_a} + {1'b0, m_effb} + {16'h0000, bus.dp_op[0]};
  always @(posedge clk) begin
    bus.dp_y  <= m_sum[15:0];
    bus.dp_co <= m_sum[16];
  end

  task automatic test_reset();
    rst_n = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_a = 16'h1234; bus.cmd_b = 16'h0001; bus.cmd_op = 3'b000;
    bus.res_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++;
      if (bus.cmd_ready !== 1'b0 || bus.res_valid !== 1'b0 || bus.busy !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_ctl cyc%0d: ready=%b res_valid=%b busy=%b, want 0/0/0",
                 i, bus.cmd_ready, bus.res_valid, bus.busy);
      end
      n_vec++;
      if (bus.dp_a !== 16'h0 || bus.dp_b !== 16'h0 || bus.dp_op !== 3'b0) begin
        n_bad++;
        $display("FAIL reset_dp cyc%0d: dp_a=%h dp_b=%h dp_op=%b, want 0",
                 i, bus.dp_a, bus.dp_b, bus.dp_op);
      end
    end
    n_vec++;
    if (bus.res_y !== 16'h0 || bus.res_co !== 1'b0 || bus.res_flags !== 3'b0) begin
      n_bad++;
      $display("FAIL reset_res: y=%h co=%b flags=%b, want 0", bus.res_y, bus.res_co, bus.res_flags);
    end
    bus.cmd_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    n_vec++;
    if (bus.cmd_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_prerelease_ready: got %b want 0", bus.cmd_ready);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_vec++;
      if (bus.cmd_ready !== 1'b1 || bus.res_valid !== 1'b0 || bus.busy !== 1'b0) begin
        n_bad++;
        $display("FAIL post_reset cyc%0d: ready=%b res_valid=%b busy=%b, want 1/0/0",
                 i, bus.cmd_ready, bus.res_valid, bus.busy);
      end
    end
    $display("reset: done");
  endtask

  task automatic test_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [2:0] op, input logic [15:0] ey, input logic eco,
                         input logic [2:0] efl_on);
    logic [2:0] efl;
    efl = FLAGS_EN ? efl_on : 3'b000;
    @(negedge clk);
    bus.res_ready = 1'b0;
    bus.cmd_valid = 1'b1; bus.cmd_a = a; bus.cmd_b = b; bus.cmd_op = op;
    n_vec++;
    if (bus.cmd_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_ready: got %b want 1", tag, bus.cmd_ready);
    end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    n_vec++;
    if (bus.dp_a !== a || bus.dp_b !== b || bus.dp_op !== op || bus.busy !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_issue: dp_a=%h dp_b=%h dp_op=%b busy=%b, want %h %h %b 1",
               tag, bus.dp_a, bus.dp_b, bus.dp_op, bus.busy, a, b, op);
    end
    @(negedge clk);
    n_vec++;
    if (bus.res_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_early: res_valid=%b after E1, want 0", tag, bus.res_valid);
    end
    @(negedge clk);
    n_vec++;
    if (bus.res_valid !== 1'b1 || bus.res_y !== ey || bus.res_co !== eco || bus.res_flags !== efl) begin
      n_bad++;
      $display("FAIL %s_result: valid=%b y=%h co=%b flags=%b, want 1 %h %b %b",
               tag, bus.res_valid, bus.res_y, bus.res_co, bus.res_flags, ey, eco, efl);
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    n_vec++;
    if (bus.res_valid !== 1'b0 || bus.res_y !== ey || bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_pop: valid=%b y=%h busy=%b, want 0 %h(held) 0",
               tag, bus.res_valid, bus.res_y, bus.busy, ey);
    end
    $display("%s: a=%h b=%h op=%b -> y=%h co=%b flags=%b", tag, a, b, op,
             bus.res_y, bus.res_co, bus.res_flags);
  endtask

  task automatic test_backpressure();
    int acc;
    int got;
    bit ready_leak;
    acc = 0; got = 0; ready_leak = 1'b0;
    bus.res_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (acc >= 4 && bus.cmd_ready) ready_leak = 1'b1;
      bus.cmd_valid = (acc < 6);
      bus.cmd_a = 16'(acc + 1); bus.cmd_b = 16'h0100; bus.cmd_op = 3'b000;
      if (bus.cmd_valid && bus.cmd_ready) acc++;
    end
    @(negedge clk);
    n_vec++;
    if (acc !== 4 || bus.cmd_ready !== 1'b0 || ready_leak) begin
      n_bad++;
      $display("FAIL bp_credit: accepted=%0d ready=%b leak=%b, want 4 0 0", acc, bus.cmd_ready, ready_leak);
    end
    bus.res_ready = 1'b1;
    for (int c = 0; c < 40 && got < 6; c++) begin
      bus.cmd_valid = (acc < 6);
      bus.cmd_a = 16'(acc + 1); bus.cmd_b = 16'h0100; bus.cmd_op = 3'b000;
      if (bus.res_valid && bus.res_ready) begin
        n_vec++;
        if (bus.res_y !== 16'(16'h0101 + got) || bus.res_co !== 1'b0) begin
          n_bad++;
          $display("FAIL bp_order%0d: y=%h co=%b, want %h 0", got, bus.res_y, bus.res_co, 16'(16'h0101 + got));
        end
        $display("bp drain %0d: y=%h", got, bus.res_y);
        got++;
      end
      if (bus.cmd_valid && bus.cmd_ready) acc++;
      @(negedge clk);
    end
    bus.cmd_valid = 1'b0;
    bus.res_ready = 1'b0;
    n_vec++;
    if (got !== 6 || acc !== 6) begin
      n_bad++;
      $display("FAIL bp_drain: results=%0d accepted=%0d, want 6 6 (budget)", got, acc);
    end
    @(negedge clk);
    n_vec++;
    if (bus.busy !== 1'b0 || bus.res_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_idle: busy=%b res_valid=%b, want 0 0", bus.busy, bus.res_valid);
    end
  endtask

  task automatic test_reset_midflight();
    bus.res_ready = 1'b0;
    bus.cmd_valid = 1'b1; bus.cmd_a = 16'h0011; bus.cmd_b = 16'h0022; bus.cmd_op = 3'b000;
    @(negedge clk);
    bus.cmd_a = 16'h0033;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_vec++;
    if (bus.busy !== 1'b0 || bus.res_valid !== 1'b0 || bus.dp_a !== 16'h0) begin
      n_bad++;
      $display("FAIL midrst_clear: busy=%b res_valid=%b dp_a=%h, want 0 0 0", bus.busy, bus.res_valid, bus.dp_a);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_vec++;
      if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0) begin
        n_bad++;
        $display("FAIL midrst_late cyc%0d: res_valid=%b busy=%b, want 0 0", i, bus.res_valid, bus.busy);
      end
    end
    $display("reset mid-flight: done");
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst_n = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_a = '0; bus.cmd_b = '0; bus.cmd_op = '0;
    bus.res_ready = 1'b0;
    test_reset();
    test_op("add",  16'h0005, 16'h0003, 3'b000, 16'h0008, 1'b0, 3'b000);
    test_op("sub_neg", 16'h0003, 16'h0005, 3'b011, 16'hFFFE, 1'b0, 3'b010);
    test_op("sub_zero", 16'h0005, 16'h0005, 3'b011, 16'h0000, 1'b1, 3'b001);
    test_op("ovf",  16'h7FFF, 16'h0001, 3'b000, 16'h8000, 1'b0, 3'b110);
    test_backpressure();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/dp_issuer.md
# dp_issuer

Command-side front end for the arithmetic datapath. Accepts operand/opcode commands over a valid/ready handshake, drives them into the datapath, and tracks each in-flight operation through the datapath's configured pipeline latency. It captures `Y`/`co` on the exact return cycle into a result FIFO, and presents results downstream over a second valid/ready handshake. Sits between the command source (sequencer/CPU port) and the datapath instance, with the result consumer on the other side.

## Interface

Parameters:
- `N`, 16: operand/result width.
- `LAT`, 1: datapath input-to-result latency in cycles (0, 1 or 2). Must match the instantiated datapath.
- `DEPTH`, 4: result FIFO entries (power of two, ≥2).

Ports:
- `clk`, in, 1: clock. All logic is on the rising edge.
- `rst_n`, in, 1: synchronous, active-low reset.
- `cmd_valid`, in, 1: command present.
- `cmd_ready`, out, 1: command accepted when `cmd_valid & cmd_ready`.
- `cmd_a`, in, N: signed operand A.
- `cmd_b`, in, N: signed operand B.
- `cmd_op`, in, 3: opcode. Bit 2 zeroes B, bit 1 inverts B, bit 0 is carry-in.
- `dp_a`, out, N: registered A to the datapath.
- `dp_b`, out, N: registered B to the datapath.
- `dp_op`, out, 3: registered opcode to the datapath.
- `dp_y`, in, N: datapath result.
- `dp_co`, in, 1: datapath carry-out.
- `res_valid`, out, 1: result available at FIFO head.
- `res_ready`, in, 1: consumer pops when `res_valid & res_ready`.
- `res_y`, out, N: result.
- `res_co`, out, 1: carry-out.
- `res_flags`, out, 3: {ovf, neg, zero}.
- `busy`, out, 1: high when any operation is in flight or the FIFO is non-empty.

## Operation

- Accept at edge E0: `dp_a`/`dp_b`/`dp_op` load the command. A valid bit and the flag side-info enter a LAT+1 stage shift register.
  - Flag side-info: sign of A, and sign of effective B, where eff B = op[2] ? 0 : (op[1] ? ~B : B).
- Idle cycles: `dp_*` hold their last values and shift in a 0 valid bit. The datapath result is ignored.
- Capture: when the shift-register tail valid bit is 1, write {`dp_y`, `dp_co`, flags} into the FIFO at that edge.
- Credit rule: `cmd_ready` = (fifo_count + inflight_count) < DEPTH, computed from current state. This guarantees a capture never finds the FIFO full, so results are never dropped.
- A same-cycle pop does not raise `cmd_ready` until the next cycle.
- Simultaneous capture and pop: count is unchanged and ordering is preserved.
- Pop on an empty FIFO is ignored. `res_*` hold their values when `res_valid` = 0.
- Results leave in strict command order.
- Arithmetic: the block passes operands through unmodified. It never alters the datapath result. `res_y` is `dp_y` verbatim.
- FIFO pointers are log2(DEPTH) bits with an extra wrap bit, so full and empty are distinguished at wrap-around.

## Timing

- Accept at E0 → `dp_*` valid after E0 → capture at E(1+LAT) → `res_valid` high in the cycle after E(1+LAT), if the FIFO was empty.
- Throughput: one command per cycle while credits remain.
- Reset (`rst_n` = 0 at an edge):
  - `dp_a`, `dp_b`, `dp_op` = 0.
  - Shift-register valid bits and FIFO pointers/count cleared.
  - `res_valid` = 0, `res_y` = 0, `res_co` = 0, `res_flags` = 0, `busy` = 0.
  - `cmd_ready` = 0 while `rst_n` = 0.
- Reset mid-operation: all in-flight operations are discarded. No capture occurs for operations issued before reset, even if their datapath result arrives after release.
- `cmd_ready` goes high in the first cycle after the releasing edge.

## Configuration

- `DP_ISSUER_FLAGS_EN` defined:
  - zero = (`dp_y` == 0).
  - neg = `dp_y`[N-1].
  - ovf = (signA == signEffB) & (`dp_y`[N-1] != signA).
- `DP_ISSUER_FLAGS_EN` undefined: no sign side-info is stored in the pipe and `res_flags` is tied to 0.

## Test plan

All scenarios use N = 16, LAT = 1, DEPTH = 4, with flags enabled unless noted.

- Reset: hold `rst_n` = 0 for 3 cycles with `cmd_valid` = 1 → `cmd_ready` = 0, `res_valid` = 0, `dp_*` = 0. After release, no spurious result appears.
- Add: A = 0x0005, B = 0x0003, op = 000, accepted at E0 → `res_valid` high after E2, `res_y` = 0x0008, co = 0, flags = 000.
- Subtract, op = 011:
  - 0x0003 − 0x0005 → 0xFFFE, co = 0, neg = 1.
  - 0x0005 − 0x0005 → 0x0000, co = 1, zero = 1.
- Overflow: 0x7FFF + 0x0001, op = 000 → 0x8000, ovf = 1, neg = 1. With `DP_ISSUER_FLAGS_EN` undefined → flags = 000, `res_y` is still 0x8000.
- Backpressure: `res_ready` = 0, offer 6 back-to-back commands → exactly 4 accepted and `cmd_ready` stays low. Then `res_ready` = 1 → 4 results drain in order, and the remaining 2 commands are then accepted.
- Reset mid-flight: accept 2 commands, pull `rst_n` low for one edge right after the second accept → FIFO empty, `busy` = 0, and no late capture occurs.
